sr_latch_driver: RTL
====================

// Module: sr_latch_driver
// PURPOSE
// - Synthesizable, self-checking driver for the far end of the S/R latch interface: drives S/R, reads back Q/Q_bar.
// - On start, plays a fixed 7-step S/R sequence: init, set, hold, reset, hold, invalid, release.
// - Checks the latch response at each step and reports pass/fail plus a per-step error mask.
// - Used for on-chip or bench checkout of the asynchronous SR latch macro.
// PARAMETERS
// - HOLD_CYCLES  4  clock cycles each step is held on S/R; legal range 3..255
// PORTS
// - clk       in   1  rising-edge clock
// - rst       in   1  asynchronous, active-high reset
// - start     in   1  begin sequence; sampled in IDLE only
// - S         out  1  set drive to latch; registered
// - R         out  1  reset drive to latch; registered
// - Q         in   1  latch output; asynchronous, synchronized internally
// - Q_bar     in   1  latch complement output; asynchronous, synchronized internally
// - busy      out  1  high while the sequence is running
// - done      out  1  one-cycle pulse when the sequence completes
// - pass      out  1  1 = no check failed in the last completed run
// - err_mask  out  7  bit i set = check at step i failed
// - step      out  3  index of the current step, 0..6
// BEHAVIOUR
// - Reset (async, immediate):
//   - S=0, R=0, busy=0, done=0, pass=0, err_mask=0, step=0, state=IDLE.
//   - Synchronizers and hold counter cleared.
// - Q/Q_bar pass through a 2-flop synchronizer each (2-cycle latency); all checks use the synchronized values.
// - Step table {S,R} / expected {Q,Q_bar} / checked:
//   - step 0: 00 / -- / no
//   - step 1: 10 / 10 / yes
//   - step 2: 00 / 10 / yes
//   - step 3: 01 / 01 / yes
//   - step 4: 00 / 01 / yes
//   - step 5: 11 / 00 / yes
//   - step 6: 00 / -- / no (race)
// - FSM: IDLE -> RUN -> DONE -> IDLE.
// - IDLE:
//   - start=1 at an edge -> next cycle: RUN, busy=1, step=0, S/R=table[0], hold_cnt=0.
//   - err_mask and pass clear on the same edge.
// - RUN:
//   - hold_cnt counts 0..HOLD_CYCLES-1.
//   - At hold_cnt==HOLD_CYCLES-1: if the step is checked and sync {Q,Q_bar} != expected, set err_mask[step].
//   - Then step+1, load the new S/R, hold_cnt=0.
//   - After step 6 completes -> DONE.
// - DONE:
//   - One cycle: done=1, busy=0, S=R=0.
//   - pass = (err_mask==0), held until the next start.
//   - Next state: IDLE.
// - Run length: busy high exactly 7*HOLD_CYCLES cycles; done follows on the next cycle.
// - start while busy or in DONE: ignored (no restart, no effect).
// - Reset mid-run: immediate abort to reset values; no done pulse.
// - S and R change only on step boundaries; never glitch within a step.
// CONFIGURATION
// - SR_DRV_LOOP_EN defined:
//   - From DONE, if start is still 1 -> RUN at step 0 (err_mask cleared, done pulse still issued).
//   - Runs back to back while start is held; otherwise -> IDLE.
// - SR_DRV_LOOP_EN undefined: one-shot; DONE always -> IDLE, and start must be re-sampled in IDLE.
// TESTING
// - Behavioural NOR latch, HOLD_CYCLES=4, start pulse -> busy 28 cycles, done pulse, pass=1, err_mask=7'b0000000.
// - Q tied 0, Q_bar tied 1 -> pass=0, err_mask=7'b0100110.
// - Q tied 1, Q_bar tied 0 -> pass=0, err_mask=7'b0111000.
// - rst pulsed while step=3 -> S=R=0, busy=0, step=0, err_mask=0 same cycle; no done; fresh start runs clean.
// - start re-pulsed at step 2 -> ignored; exactly one done pulse, 28 cycles after start.
// - SR_DRV_LOOP_EN, start held -> done pulses every 29 cycles, pass=1 each run; drop start -> IDLE after current run.

Source files
------------

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: plays a 7-step S/R sequence into an async SR latch and checks Q/Q_bar.
// Define SR_DRV_LOOP_EN to rerun back to back while start stays high.
module sr_latch_driver #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       S,
    output logic       R,
    input  logic       Q,
    input  logic       Q_bar,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_mask,
    output logic [2:0] step
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Step tables, bit i belongs to step i.
    localparam logic [7:0] S_TAB   = 8'b0010_0010;
    localparam logic [7:0] R_TAB   = 8'b0010_1000;
    localparam logic [7:0] EXP_Q   = 8'b0000_0110;
    localparam logic [7:0] EXP_QB  = 8'b0001_1000;
    localparam logic [7:0] CHK_TAB = 8'b0011_1110;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] hold_cnt;
    logic [1:0] q_sync, qb_sync;
    logic [2:0] step_inc;
    logic       step_end, last_step, fail, begin_run, loop_again;
    logic [6:0] err_nxt;

    assign busy = state == RUN;
    assign done = state == DONE;

`ifdef SR_DRV_LOOP_EN
    assign loop_again = start;
`else
    assign loop_again = 1'b0;
`endif

    always_comb begin
        step_inc  = step + 3'd1;
        step_end  = busy && hold_cnt == HOLD_LAST;
        last_step = step_end && step == 3'd6;
        fail      = CHK_TAB[step] && {q_sync[1], qb_sync[1]} != {EXP_Q[step], EXP_QB[step]};
        err_nxt   = err_mask | (fail ? 7'(1) << step : 7'd0);
        begin_run = (state == IDLE && start) || (done && loop_again);
        state_nxt = state;
        if (state == IDLE)
            state_nxt = start ? RUN : IDLE;
        else if (busy)
            state_nxt = last_step ? DONE : RUN;
        else
            state_nxt = loop_again ? RUN : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            S        <= 1'b0;
            R        <= 1'b0;
            pass     <= 1'b0;
            err_mask <= '0;
            step     <= '0;
            hold_cnt <= '0;
            q_sync   <= '0;
            qb_sync  <= '0;
        end else begin
            state   <= state_nxt;
            q_sync  <= {q_sync[0], Q};
            qb_sync <= {qb_sync[0], Q_bar};
            if (begin_run) begin
                step     <= '0;
                hold_cnt <= '0;
                err_mask <= '0;
                pass     <= 1'b0;
                S        <= S_TAB[0];
                R        <= R_TAB[0];
            end else if (step_end) begin
                err_mask <= err_nxt;
                hold_cnt <= '0;
                if (last_step) begin
                    S    <= 1'b0;
                    R    <= 1'b0;
                    pass <= err_nxt == 7'd0;
                end else begin
                    step <= step_inc;
                    S    <= S_TAB[step_inc];
                    R    <= R_TAB[step_inc];
                end
            end else if (busy) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end
endmodule
